// File: rtl/reg_bank_pkg.sv
// Shared constants and clear-FSM encoding for the MSP430-style register bank.
package reg_bank_pkg;

    localparam int unsigned DW     = 16;
    localparam int unsigned NREG   = 16;
    localparam int unsigned AW     = 4;

    localparam int unsigned PC_IDX = 0;
    localparam int unsigned SP_IDX = 1;
    localparam int unsigned SR_IDX = 2;
    localparam int unsigned CG_IDX = 3;

    // SR bit positions fed by the {V,N,Z,C} flag port
    localparam int unsigned SR_C_BIT = 0;
    localparam int unsigned SR_Z_BIT = 1;
    localparam int unsigned SR_N_BIT = 2;
    localparam int unsigned SR_V_BIT = 8;

    typedef enum logic {
        StIdle,
        StClear
    } clr_state_e;

endpackage

// File: rtl/reg_clear_seq.sv
// Clear sequencer: walks indices 0..NREG-1, one register zeroed per cycle.
module reg_clear_seq
    import reg_bank_pkg::*;
#(
    parameter int unsigned NREG = reg_bank_pkg::NREG,
    parameter int unsigned AW   = reg_bank_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            end
            StClear: begin
                if (idx_q == LAST_IDX) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    assign busy    = (state_q == StClear);
    assign clr_we  = busy;
    assign clr_idx = idx_q;

endmodule

// File: rtl/reg_bank_param.sv
// CPU register bank: two registered read ports, general write, PC update, SR flag update and
// a sequenced clear. Define BANK_BYPASS_EN for same-edge write-to-read forwarding.
module reg_bank_param
    import reg_bank_pkg::*;
#(
    parameter int unsigned DW     = reg_bank_pkg::DW,
    parameter int unsigned NREG   = reg_bank_pkg::NREG,
    parameter int unsigned AW     = reg_bank_pkg::AW,
    parameter int unsigned PC_IDX = reg_bank_pkg::PC_IDX,
    parameter int unsigned SR_IDX = reg_bank_pkg::SR_IDX,
    parameter int unsigned CG_IDX = reg_bank_pkg::CG_IDX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] src_reg,
    input  logic [AW-1:0] dst_reg,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_reg,
    input  logic [DW-1:0] wr_data,
    input  logic          pc_inc,
    input  logic [DW-1:0] pc_data_in,
    output logic [DW-1:0] pc_data_out,
    input  logic          sr_wr_en,
    input  logic [3:0]    sr_flags,
    input  logic          clr_req,
    output logic          busy
);

    localparam logic [AW-1:0] PC_SEL = AW'(PC_IDX);
    localparam logic [AW-1:0] CG_SEL = AW'(CG_IDX);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [DW-1:0] sr_upd;
    logic [DW-1:0] a_d, b_d, pc_d;
    logic          clr_we;
    logic [AW-1:0] clr_idx;

    reg_clear_seq #(
        .NREG (NREG),
        .AW   (AW)
    ) u_clear_seq (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    always_comb begin
        sr_upd           = regs_q[SR_IDX];
        sr_upd[SR_V_BIT] = sr_flags[3];
        sr_upd[SR_N_BIT] = sr_flags[2];
        sr_upd[SR_Z_BIT] = sr_flags[1];
        sr_upd[SR_C_BIT] = sr_flags[0];
    end

    // Priority: clear > general write > PC update / SR flags; CG is pinned to zero.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (clr_we) begin
                if (clr_idx == AW'(i)) begin
                    regs_d[i] = '0;
                end
            end else if (wr_en && (wr_reg == AW'(i))) begin
                regs_d[i] = wr_data;
            end else if ((i == PC_IDX) && pc_inc) begin
                regs_d[i] = pc_data_in;
            end else if ((i == SR_IDX) && sr_wr_en) begin
                regs_d[i] = sr_upd;
            end
            if (i == CG_IDX) begin
                regs_d[i] = '0;
            end
        end
    end

    always_comb begin
        a_d  = '0;
        b_d  = '0;
        pc_d = '0;
        if (!clr_we) begin
`ifdef BANK_BYPASS_EN
            a_d  = regs_d[src_reg];
            b_d  = regs_d[dst_reg];
            pc_d = regs_d[PC_SEL];
`else
            a_d  = regs_q[src_reg];
            b_d  = regs_q[dst_reg];
            pc_d = regs_q[PC_SEL];
`endif
            if (src_reg == CG_SEL) a_d = '0;
            if (dst_reg == CG_SEL) b_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            a           <= '0;
            b           <= '0;
            pc_data_out <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            a           <= a_d;
            b           <= b_d;
            pc_data_out <= pc_d;
        end
    end

endmodule

// File: tb/tb_reg_bank_param.sv
// Self-checking bench for reg_bank_param: behavioural model plus directed literal checks.
module tb_reg_bank_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src_reg = '0, dst_reg = '0, wr_reg = '0;
    logic [15:0] a, b, pc_data_out;
    logic        wr_en = 1'b0, pc_inc = 1'b0, sr_wr_en = 1'b0, clr_req = 1'b0;
    logic [15:0] wr_data = '0, pc_data_in = '0;
    logic [3:0]  sr_flags = '0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    reg_bank_param dut (
        .clk         (clk),
        .rst         (rst),
        .src_reg     (src_reg),
        .dst_reg     (dst_reg),
        .a           (a),
        .b           (b),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .pc_inc      (pc_inc),
        .pc_data_in  (pc_data_in),
        .pc_data_out (pc_data_out),
        .sr_wr_en    (sr_wr_en),
        .sr_flags    (sr_flags),
        .clr_req     (clr_req),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file as a plain array, clear as a countdown.
    logic [15:0] m_regs [16];
    logic [15:0] ea = '0, eb = '0, epc = '0;
    int          clr_left = 0;

    initial for (int i = 0; i < 16; i++) m_regs[i] = '0;

    always @(posedge clk) begin
        logic [15:0] nw [16];
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            ea = '0; eb = '0; epc = '0; clr_left = 0;
        end else if (clr_left > 0) begin
            m_regs[16 - clr_left] = '0;
            clr_left--;
            ea = '0; eb = '0; epc = '0;
        end else begin
            nw = m_regs;
            if (sr_wr_en) begin
                nw[2][8]   = sr_flags[3];
                nw[2][2:0] = sr_flags[2:0];
            end
            if (pc_inc) nw[0] = pc_data_in;
            if (wr_en) nw[wr_reg] = wr_data;
            nw[3] = '0;
`ifdef BANK_BYPASS_EN
            ea = nw[src_reg]; eb = nw[dst_reg]; epc = nw[0];
`else
            ea = m_regs[src_reg]; eb = m_regs[dst_reg]; epc = m_regs[0];
`endif
            m_regs = nw;
            if (clr_req) clr_left = 16;
        end
    end

    always begin
        @(posedge clk);
        #2;
        chk("model_a", a, ea);
        chk("model_b", b, eb);
        chk("model_pc", pc_data_out, epc);
        chk("model_busy", {15'b0, busy}, {15'b0, clr_left > 0});
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 0; pc_inc = 0; sr_wr_en = 0; clr_req = 0;
    endtask

    task automatic wr(input logic [3:0] r, input logic [15:0] d);
        wr_en = 1; wr_reg = r; wr_data = d;
    endtask

    int busy_cnt;
    int guard;

    initial begin
        idle();
        repeat (2) step();
        rst = 0;
        step();

        // Same-cycle general write and PC update
        wr(5, 16'h1234); pc_inc = 1; pc_data_in = 16'h0042;
        step();
        idle(); src_reg = 5; dst_reg = 0;
        step();
        chk("t2_r5", a, 16'h1234);
        chk("t2_pc", pc_data_out, 16'h0042);

        // General write to PC beats pc_inc
        wr(0, 16'h0100); pc_inc = 1; pc_data_in = 16'h0200;
        step();
        idle();
        step();
        chk("t3_pc", pc_data_out, 16'h0100);
        chk("t3_b_pc", b, 16'h0100);

        // SR flag update touches only bits 8,2,1,0
        wr(2, 16'hFFFF);
        step();
        idle(); sr_wr_en = 1; sr_flags = 4'b0000;
        step();
        idle(); dst_reg = 2;
        step();
        chk("t4_sr_flags", b, 16'hFEF8);
        wr(2, 16'h1234); sr_wr_en = 1; sr_flags = 4'b1111;
        step();
        idle();
        step();
        chk("t4_sr_wr_wins", b, 16'h1234);

        // CG writes dropped
        wr(3, 16'hBEEF);
        step();
        idle(); src_reg = 3;
        step();
        chk("t4_cg", a, 16'h0000);

        // Clear sequence: busy window, writes dropped, clr_req while busy ignored
        wr(4, 16'h5555);
        step();
        idle(); clr_req = 1;
        step();
        clr_req = 0;
        busy_cnt = 0;
        guard = 0;
        while ((busy || busy_cnt == 0) && guard < 40) begin
            if (busy) begin
                busy_cnt++;
                wr_en = (busy_cnt == 1); wr_reg = 4; wr_data = 16'hABCD;
                clr_req = (busy_cnt == 5);
            end
            step();
            guard++;
        end
        idle();
        chk("t5_busy_cycles", 16'(busy_cnt), 16'd16);
        for (int i = 0; i < 16; i++) begin
            src_reg = 4'(i);
            step();
            chk($sformatf("t5_r%0d_zero", i), a, 16'h0000);
        end
        chk("t5_busy_after", {15'b0, busy}, 16'h0000);

        // Asynchronous reset mid-run
        wr(9, 16'h9999); pc_inc = 1; pc_data_in = 16'h0BEE;
        step();
        idle(); src_reg = 9; dst_reg = 9;
        step();
        chk("t1_pre_a", a, 16'h9999);
        #1 rst = 1;
        #1;
        chk("t1_rst_a", a, 16'h0000);
        chk("t1_rst_b", b, 16'h0000);
        chk("t1_rst_pc", pc_data_out, 16'h0000);
        chk("t1_rst_busy", {15'b0, busy}, 16'h0000);
        step();
        rst = 0;
        step();
        step();
        chk("t1_r9_zero", a, 16'h0000);
        chk("t1_pc_zero", pc_data_out, 16'h0000);

        // Forwarding behaviour
        wr(7, 16'h00AA); src_reg = 7;
        step();
        idle();
`ifdef BANK_BYPASS_EN
        chk("t6_same_edge", a, 16'h00AA);
`else
        chk("t6_same_edge", a, 16'h0000);
`endif
        step();
        chk("t6_next_edge", a, 16'h00AA);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            src_reg    = 4'($urandom_range(0, 15));
            dst_reg    = 4'($urandom_range(0, 15));
            wr_en      = ($urandom_range(0, 3) != 0);
            wr_reg     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 3))
                                                     : 4'($urandom_range(0, 15));
            wr_data    = 16'($urandom);
            pc_inc     = ($urandom_range(0, 1) != 0);
            pc_data_in = 16'($urandom);
            sr_wr_en   = ($urandom_range(0, 2) == 0);
            sr_flags   = 4'($urandom);
            clr_req    = ($urandom_range(0, 63) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            step();
            rst = 0;
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
